// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline-side hazard inputs and control outputs.
// Stats outputs exist only when HAZARD_STATS_EN is defined.
interface pipeline_hazard_ctrl_if #(
  parameter int STAT_WIDTH = 16
);
  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic [4:0] rs_ex;
  logic [4:0] rt_ex;
  logic       mem_read_ex;
  logic [4:0] rd_mem;
  logic       reg_write_mem;
  logic [4:0] rd_wb;
  logic       reg_write_wb;
  logic       branch_taken_ex;
  logic       mdu_start_id;
  logic       mdu_use_id;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       mdu_busy;
`ifdef HAZARD_STATS_EN
  logic [STAT_WIDTH-1:0] stall_cycles;
  logic [STAT_WIDTH-1:0] flush_count;
`endif

  modport master (
    output rs_id, rt_id, rs_ex, rt_ex,
    output mem_read_ex, rd_mem, reg_write_mem,
    output rd_wb, reg_write_wb,
    output branch_taken_ex, mdu_start_id, mdu_use_id,
    input  pc_write, if_id_write,
    input  if_id_flush, id_ex_flush,
    input  fwd_a, fwd_b, mdu_busy
`ifdef HAZARD_STATS_EN
    ,
    input  stall_cycles, flush_count
`endif
  );

  modport slave (
    input  rs_id, rt_id, rs_ex, rt_ex,
    input  mem_read_ex, rd_mem, reg_write_mem,
    input  rd_wb, reg_write_wb,
    input  branch_taken_ex, mdu_start_id, mdu_use_id,
    output pc_write, if_id_write,
    output if_id_flush, id_ex_flush,
    output fwd_a, fwd_b, mdu_busy
`ifdef HAZARD_STATS_EN
    ,
    output stall_cycles, flush_count
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: stalls, flushes, forwarding, MDU busy sequencing.
// Optional HAZARD_STATS_EN adds saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int MDU_LATENCY = 32,
  parameter int STAT_WIDTH  = 16
) (
  input  logic clk,
  input  logic rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  if (MDU_LATENCY < 1 || MDU_LATENCY > 255 || STAT_WIDTH < 1)
  begin : g_bad_param
    $error("pipeline_hazard_ctrl: illegal parameter");
  end

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  localparam logic [7:0] CNT_INIT = 8'(MDU_LATENCY - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic mem_hit_a, wb_hit_a;
  logic mem_hit_b, wb_hit_b;
  logic load_use;
  logic mdu_stall;
  logic start_ok;
  logic do_flush;
  logic do_stall;

  // Hazard detection terms shared by outputs, FSM and stats
  always_comb begin
    mem_hit_a = hz.reg_write_mem && (hz.rd_mem != 5'd0)
             && (hz.rd_mem == hz.rs_ex);
    wb_hit_a  = hz.reg_write_wb && (hz.rd_wb != 5'd0)
             && (hz.rd_wb == hz.rs_ex);
    mem_hit_b = hz.reg_write_mem && (hz.rd_mem != 5'd0)
             && (hz.rd_mem == hz.rt_ex);
    wb_hit_b  = hz.reg_write_wb && (hz.rd_wb != 5'd0)
             && (hz.rd_wb == hz.rt_ex);
    load_use  = hz.mem_read_ex && (hz.rt_ex != 5'd0)
             && ((hz.rt_ex == hz.rs_id) || (hz.rt_ex == hz.rt_id));
    mdu_stall = (state_q == BUSY)
             && (hz.mdu_start_id || hz.mdu_use_id)
             && !((cnt_q == 8'd0) && hz.mdu_use_id && !hz.mdu_start_id);
    start_ok  = hz.mdu_start_id && !hz.branch_taken_ex && !load_use;
    do_flush  = rst_n && hz.branch_taken_ex;
    do_stall  = rst_n && !hz.branch_taken_ex && (load_use || mdu_stall);
  end

  // Forwarding selects: MEM result beats WB result, reset forces regfile
  always_comb begin
    hz.fwd_a = 2'b00;
    hz.fwd_b = 2'b00;
    if (rst_n) begin
      if (mem_hit_a)     hz.fwd_a = 2'b10;
      else if (wb_hit_a) hz.fwd_a = 2'b01;
      if (mem_hit_b)     hz.fwd_b = 2'b10;
      else if (wb_hit_b) hz.fwd_b = 2'b01;
    end
  end

  // Pipeline enables and flushes in priority order
  always_comb begin
    hz.pc_write    = 1'b1;
    hz.if_id_write = 1'b1;
    hz.if_id_flush = 1'b0;
    hz.id_ex_flush = 1'b0;
    unique case (1'b1)
      !rst_n: begin
        hz.pc_write    = 1'b0;
        hz.if_id_write = 1'b0;
        hz.if_id_flush = 1'b1;
        hz.id_ex_flush = 1'b1;
      end
      do_flush: begin
        hz.if_id_flush = 1'b1;
        hz.id_ex_flush = 1'b1;
      end
      do_stall: begin
        hz.pc_write    = 1'b0;
        hz.if_id_write = 1'b0;
        hz.id_ex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  // MDU busy FSM next state and down-counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!rst_n) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // MDU state register, clocked with the pipeline registers
  always_ff @(negedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  assign hz.mdu_busy = (state_q == BUSY);

`ifdef HAZARD_STATS_EN
  logic [STAT_WIDTH-1:0] stall_q, stall_d;
  logic [STAT_WIDTH-1:0] flush_q, flush_d;

  // Saturating stall-cycle and flush counters
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!rst_n) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (do_stall && !(&stall_q)) stall_d = stall_q + 1'b1;
      if (do_flush && !(&flush_q)) flush_d = flush_q + 1'b1;
    end
  end

  // Statistics registers
  always_ff @(negedge clk) begin
    stall_q <= stall_d;
    flush_q <= flush_d;
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MDU_LATENCY=4.
// Stats checks run only when HAZARD_STATS_EN is defined.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  pipeline_hazard_ctrl_if #(.STAT_WIDTH(2)) hif ();

  pipeline_hazard_ctrl #(
    .MDU_LATENCY(4),
    .STAT_WIDTH (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hif)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h exp %0h", tag, got, exp);
  endtask

  function automatic logic [3:0] ctl();
    return {hif.pc_write, hif.if_id_write,
            hif.if_id_flush, hif.id_ex_flush};
  endfunction

  task automatic clear();
    hif.rs_id           = 5'd0;
    hif.rt_id           = 5'd0;
    hif.rs_ex           = 5'd0;
    hif.rt_ex           = 5'd0;
    hif.mem_read_ex     = 1'b0;
    hif.rd_mem          = 5'd0;
    hif.reg_write_mem   = 1'b0;
    hif.rd_wb           = 5'd0;
    hif.reg_write_wb    = 1'b0;
    hif.branch_taken_ex = 1'b0;
    hif.mdu_start_id    = 1'b0;
    hif.mdu_use_id      = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    clear();
    rst_n = 1'b0;
    hif.rd_mem        = 5'd5;
    hif.reg_write_mem = 1'b1;
    hif.rs_ex         = 5'd5;
    #1;
    check("rst_ctl", 32'(ctl()), 32'b0011);
    check("rst_fwd_a", 32'(hif.fwd_a), 32'd0);
    tick();
    check("rst_busy", 32'(hif.mdu_busy), 32'd0);
    rst_n = 1'b1;
    clear();

    hif.rd_mem = 5'd5; hif.rd_wb = 5'd5;
    hif.reg_write_mem = 1'b1; hif.reg_write_wb = 1'b1;
    hif.rs_ex = 5'd5; hif.rt_ex = 5'd5;
    #1;
    check("fwd_a_mem", 32'(hif.fwd_a), 32'd2);
    check("fwd_b_mem", 32'(hif.fwd_b), 32'd2);
    check("fwd_ctl", 32'(ctl()), 32'b1100);
    hif.reg_write_mem = 1'b0;
    #1;
    check("fwd_a_wb", 32'(hif.fwd_a), 32'd1);
    check("fwd_b_wb", 32'(hif.fwd_b), 32'd1);
    hif.reg_write_mem = 1'b1; hif.rd_mem = 5'd0; hif.rs_ex = 5'd0;
    hif.rt_ex = 5'd5;
    #1;
    check("fwd_r0", 32'(hif.fwd_a), 32'd0);
    check("fwd_b_r0mem", 32'(hif.fwd_b), 32'd1);
    hif.reg_write_wb = 1'b0;
    #1;
    check("fwd_none", 32'(hif.fwd_b), 32'd0);
    hif.rd_mem = 5'd7; hif.rt_ex = 5'd7; hif.rs_ex = 5'd5;
    hif.rd_wb = 5'd5; hif.reg_write_wb = 1'b1;
    #1;
    check("fwd_a_mix", 32'(hif.fwd_a), 32'd1);
    check("fwd_b_mix", 32'(hif.fwd_b), 32'd2);
    tick();
    clear();

    hif.mem_read_ex = 1'b1; hif.rt_ex = 5'd3; hif.rs_id = 5'd3;
    #1;
    check("lu_rs", 32'(ctl()), 32'b0001);
    tick();
    clear();
    #1;
    check("lu_release", 32'(ctl()), 32'b1100);
    tick();
    hif.mem_read_ex = 1'b1; hif.rt_ex = 5'd3; hif.rt_id = 5'd3;
    #1;
    check("lu_rt", 32'(ctl()), 32'b0001);
    tick();
    clear();
    hif.mem_read_ex = 1'b1;
    #1;
    check("lu_r0", 32'(ctl()), 32'b1100);
    tick();
    clear();

    hif.mdu_start_id = 1'b1;
    #1;
    check("mul_issue", 32'(ctl()), 32'b1100);
    check("mul_busy0", 32'(hif.mdu_busy), 32'd0);
    tick();
    clear();
    hif.mdu_use_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("mflo_busy%0d", i), 32'(hif.mdu_busy), 32'd1);
      check($sformatf("mflo_stall%0d", i), 32'(ctl()), 32'b0001);
      tick();
    end
    #1;
    check("mflo_last_busy", 32'(hif.mdu_busy), 32'd1);
    check("mflo_issue", 32'(ctl()), 32'b1100);
    tick();
    clear();
    #1;
    check("mul_done", 32'(hif.mdu_busy), 32'd0);

    hif.mdu_start_id = 1'b1;
    #1;
    check("mulA_issue", 32'(ctl()), 32'b1100);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("mulB_busy%0d", i), 32'(hif.mdu_busy), 32'd1);
      check($sformatf("mulB_stall%0d", i), 32'(ctl()), 32'b0001);
      tick();
    end
    #1;
    check("mulB_idle", 32'(hif.mdu_busy), 32'd0);
    check("mulB_issue", 32'(ctl()), 32'b1100);
    tick();
    clear();

    #1;
    check("rstmid_busy3", 32'(hif.mdu_busy), 32'd1);
    tick();
    rst_n = 1'b0;
    hif.rd_mem = 5'd5; hif.reg_write_mem = 1'b1; hif.rs_ex = 5'd5;
    #1;
    check("rstmid_ctl", 32'(ctl()), 32'b0011);
    check("rstmid_fwd", 32'(hif.fwd_a), 32'd0);
    tick();
    rst_n = 1'b1;
    clear();
    #1;
    check("rstmid_idle", 32'(hif.mdu_busy), 32'd0);
    check("rstmid_ctl2", 32'(ctl()), 32'b1100);
    tick();
    #1;
    check("rstmid_stay", 32'(hif.mdu_busy), 32'd0);

    hif.branch_taken_ex = 1'b1;
    hif.mem_read_ex = 1'b1; hif.rt_ex = 5'd3; hif.rs_id = 5'd3;
    hif.mdu_start_id = 1'b1;
    #1;
    check("br_ctl", 32'(ctl()), 32'b1111);
    tick();
    clear();
    #1;
    check("br_no_start", 32'(hif.mdu_busy), 32'd0);

    hif.mdu_start_id = 1'b1;
    tick();
    clear();
    hif.branch_taken_ex = 1'b1; hif.mdu_start_id = 1'b1;
    #1;
    check("br_busy_ctl", 32'(ctl()), 32'b1111);
    check("br_busy", 32'(hif.mdu_busy), 32'd1);
    tick();
    clear();
    tick();
    tick();
    tick();
    #1;
    check("br_drain", 32'(hif.mdu_busy), 32'd0);

`ifdef HAZARD_STATS_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("st_rst_stall", 32'(hif.stall_cycles), 32'd0);
    check("st_rst_flush", 32'(hif.flush_count), 32'd0);
    hif.mem_read_ex = 1'b1; hif.rt_ex = 5'd3; hif.rs_id = 5'd3;
    tick();
    tick();
    #1;
    check("st_stall2", 32'(hif.stall_cycles), 32'd2);
    tick();
    tick();
    tick();
    #1;
    check("st_stall_sat", 32'(hif.stall_cycles), 32'd3);
    clear();
    hif.branch_taken_ex = 1'b1;
    tick();
    clear();
    #1;
    check("st_flush1", 32'(hif.flush_count), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("st_clr_stall", 32'(hif.stall_cycles), 32'd0);
    check("st_clr_flush", 32'(hif.flush_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
